// File: rtl/b_stage_arbiter_if.sv
// rtl/b_stage_arbiter_if.sv - handshake bundle between two requesters, the arbiter and the branch stage
interface b_stage_arbiter_if #(
  parameter int PW = 38,
  parameter int CW = 8
);
  logic [PW-1:0] packet_in_a;
  logic          send_in_a;
  logic          ack_out_a;
  logic [PW-1:0] packet_in_b;
  logic          send_in_b;
  logic          ack_out_b;
  logic [PW-1:0] packet_out;
  logic          send_out;
  logic          ack_in;
  logic          grant_b;
  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  modport master (
    output packet_in_a, send_in_a, packet_in_b, send_in_b, ack_in,
    input  ack_out_a, ack_out_b, packet_out, send_out, grant_b, cnt_a, cnt_b
  );

  modport slave (
    input  packet_in_a, send_in_a, packet_in_b, send_in_b, ack_in,
    output ack_out_a, ack_out_b, packet_out, send_out, grant_b, cnt_a, cnt_b
  );
endinterface

// File: rtl/b_stage_arbiter.sv
// rtl/b_stage_arbiter.sv - two-input four-phase merge arbiter with alternating priority and per-port counters
module b_stage_arbiter #(
  parameter int PW = 38,
  parameter int CW = 8
) (
  input logic              cp,
  input logic              mr_n,
  b_stage_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t        state_q, state_n;
  logic          pri_q, pri_n;
  logic [PW-1:0] pkt_q, pkt_n;
  logic          send_q, send_n;
  logic          ack_a_q, ack_a_n;
  logic          ack_b_q, ack_b_n;
  logic          gb_q, gb_n;
  logic [CW-1:0] cnt_a_q, cnt_a_n;
  logic [CW-1:0] cnt_b_q, cnt_b_n;

  logic elig_a, elig_b, pick_b;

  // A port that still holds its ack has not finished its own four-phase cycle.
  assign elig_a = bus.send_in_a & ~ack_a_q;
  assign elig_b = bus.send_in_b & ~ack_b_q;
  assign pick_b = elig_b & (~elig_a | pri_q);

  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      state_q <= IDLE;
      pri_q   <= 1'b0;
      pkt_q   <= '0;
      send_q  <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      gb_q    <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_n;
      pri_q   <= pri_n;
      pkt_q   <= pkt_n;
      send_q  <= send_n;
      ack_a_q <= ack_a_n;
      ack_b_q <= ack_b_n;
      gb_q    <= gb_n;
      cnt_a_q <= cnt_a_n;
      cnt_b_q <= cnt_b_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pri_n   = pri_q;
    pkt_n   = pkt_q;
    send_n  = send_q;
    ack_a_n = ack_a_q;
    ack_b_n = ack_b_q;
    gb_n    = gb_q;
    cnt_a_n = cnt_a_q;
    cnt_b_n = cnt_b_q;

    // Upstream acks follow their own requester regardless of downstream phase.
    if (!bus.send_in_a) ack_a_n = 1'b0;
    if (!bus.send_in_b) ack_b_n = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig_a || elig_b) begin
          state_n = SEND;
          send_n  = 1'b1;
          gb_n    = pick_b;
          pkt_n   = pick_b ? bus.packet_in_b : bus.packet_in_a;
          if (pick_b) ack_b_n = 1'b1;
          else        ack_a_n = 1'b1;
        end
      end
      SEND: begin
        if (bus.ack_in) begin
          send_n  = 1'b0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.ack_in) begin
          state_n = IDLE;
          pri_n   = ~gb_q;
          if (gb_q) cnt_b_n = cnt_b_q + CW'(1);
          else      cnt_a_n = cnt_a_q + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ack_out_a  = ack_a_q;
  assign bus.ack_out_b  = ack_b_q;
  assign bus.packet_out = pkt_q;
  assign bus.send_out   = send_q;
  assign bus.grant_b    = gb_q;
  assign bus.cnt_a      = cnt_a_q;
  assign bus.cnt_b      = cnt_b_q;
endmodule

// File: tb/tb_b_stage_arbiter.sv
// tb/tb_b_stage_arbiter.sv - vector table, directed corner sequences and randomized model comparison for b_stage_arbiter
module tb_b_stage_arbiter;
  localparam int PW = 38;
  localparam int CW = 8;
  localparam logic [PW-1:0] PKT_A = 38'h0012345678;
  localparam logic [PW-1:0] PKT_B = 38'h2ABCDEF012;

  logic cp = 1'b0;
  logic mr_n = 1'b0;

  b_stage_arbiter_if #(.PW(PW), .CW(CW)) bus ();
  b_stage_arbiter #(.PW(PW), .CW(CW)) dut (.cp(cp), .mr_n(mr_n), .bus(bus));

  always #5 cp = ~cp;

  int errs = 0;
  int checks = 0;
  int grants[$];

  typedef struct packed {
    logic       sa, sb, ai;
    logic       so, gb, aa, ab;
    logic [1:0] pk;
    logic [7:0] ca, cb;
  } vec_t;

  vec_t tbl[12];

  // reference model state (transaction-level view)
  bit m_busy, m_rel, m_pri, m_so, m_gb;
  bit m_ack[2];
  logic [PW-1:0] m_pkt;
  int m_cnt[2];

  function automatic vec_t mk(input logic sa, sb, ai, so, gb, aa, ab, input logic [1:0] pk,
                              input logic [7:0] ca, cb);
    vec_t v;
    v = {sa, sb, ai, so, gb, aa, ab, pk, ca, cb};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic do_reset();
    mr_n = 1'b0;
    bus.send_in_a = 1'b0;
    bus.send_in_b = 1'b0;
    bus.ack_in = 1'b0;
    bus.packet_in_a = PKT_A;
    bus.packet_in_b = PKT_B;
    tick();
    tick();
    mr_n = 1'b1;
    m_busy = 0; m_rel = 0; m_pri = 0; m_so = 0; m_gb = 0;
    m_ack[0] = 0; m_ack[1] = 0; m_pkt = '0; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic m_step(input bit sa, input bit sb, input logic [PW-1:0] pa,
                        input logic [PW-1:0] pb, input bit ai);
    bit e0, e1;
    int g;
    if (!m_busy) begin
      e0 = sa && !m_ack[0];
      e1 = sb && !m_ack[1];
      if (e0 || e1) begin
        g = (e0 && e1) ? (m_pri ? 1 : 0) : (e1 ? 1 : 0);
        m_pkt = (g == 1) ? pb : pa;
        m_ack[g] = 1;
        m_gb = (g == 1);
        m_so = 1;
        m_busy = 1;
      end
    end else if (!m_rel) begin
      if (ai) begin
        m_so = 0;
        m_rel = 1;
      end
    end else if (!ai) begin
      m_busy = 0;
      m_rel = 0;
      m_pri = !m_gb;
      m_cnt[m_gb ? 1 : 0] = (m_cnt[m_gb ? 1 : 0] + 1) % (1 << CW);
    end
    if (!sa) m_ack[0] = 0;
    if (!sb) m_ack[1] = 0;
  endtask

  // Compliant four-phase requesters and a downstream that echoes send_out.
  task automatic drive_4ph(input bit en_a, input bit en_b, input int want);
    int n;
    int cyc;
    bit prev_so;
    n = 0;
    cyc = 0;
    grants.delete();
    prev_so = bus.send_out;
    bus.send_in_a = en_a;
    bus.send_in_b = en_b;
    bus.ack_in = 1'b0;
    while (n < want && cyc < want * 12 + 20) begin
      tick();
      cyc++;
      if (bus.send_out && !prev_so) begin
        grants.push_back(bus.grant_b ? 1 : 0);
        n++;
      end
      prev_so = bus.send_out;
      if (n < want) begin
        bus.send_in_a = en_a && !bus.ack_out_a;
        bus.send_in_b = en_b && !bus.ack_out_b;
      end else begin
        bus.send_in_a = 1'b0;
        bus.send_in_b = 1'b0;
      end
      bus.ack_in = bus.send_out;
    end
    chk("4ph_grant_count", 64'(n), 64'(want));
    repeat (8) begin
      tick();
      bus.send_in_a = 1'b0;
      bus.send_in_b = 1'b0;
      bus.ack_in = bus.send_out;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] exp_pkt;
    logic [PW-1:0] pa, pb;
    bit sa, sb, ai;

    tbl[0]  = mk(1, 1, 0,  1, 0, 1, 0, 2'd1, 8'd0, 8'd0);
    tbl[1]  = mk(1, 1, 1,  0, 0, 1, 0, 2'd1, 8'd0, 8'd0);
    tbl[2]  = mk(0, 1, 1,  0, 0, 0, 0, 2'd1, 8'd0, 8'd0);
    tbl[3]  = mk(0, 1, 0,  0, 0, 0, 0, 2'd1, 8'd1, 8'd0);
    tbl[4]  = mk(0, 1, 0,  1, 1, 0, 1, 2'd2, 8'd1, 8'd0);
    tbl[5]  = mk(1, 1, 1,  0, 1, 0, 1, 2'd2, 8'd1, 8'd0);
    tbl[6]  = mk(1, 0, 0,  0, 1, 0, 0, 2'd2, 8'd1, 8'd1);
    tbl[7]  = mk(1, 0, 1,  1, 0, 1, 0, 2'd1, 8'd1, 8'd1);
    tbl[8]  = mk(1, 0, 0,  1, 0, 1, 0, 2'd1, 8'd1, 8'd1);
    tbl[9]  = mk(0, 0, 0,  1, 0, 0, 0, 2'd1, 8'd1, 8'd1);
    tbl[10] = mk(0, 0, 1,  0, 0, 0, 0, 2'd1, 8'd1, 8'd1);
    tbl[11] = mk(0, 0, 0,  0, 0, 0, 0, 2'd1, 8'd2, 8'd1);

    do_reset();
    chk("reset_ctl", 64'({bus.send_out, bus.grant_b, bus.ack_out_a, bus.ack_out_b}), 64'(0));
    chk("reset_pkt", 64'(bus.packet_out), 64'(0));
    chk("reset_cnt", 64'({bus.cnt_a, bus.cnt_b}), 64'(0));

    for (int i = 0; i < 12; i++) begin
      bus.send_in_a = tbl[i].sa;
      bus.send_in_b = tbl[i].sb;
      bus.ack_in = tbl[i].ai;
      tick();
      exp_pkt = (tbl[i].pk == 2'd1) ? PKT_A : (tbl[i].pk == 2'd2) ? PKT_B : '0;
      chk($sformatf("vec%0d_ctl", i),
          64'({bus.send_out, bus.grant_b, bus.ack_out_a, bus.ack_out_b}),
          64'({tbl[i].so, tbl[i].gb, tbl[i].aa, tbl[i].ab}));
      chk($sformatf("vec%0d_pkt", i), 64'(bus.packet_out), 64'(exp_pkt));
      chk($sformatf("vec%0d_cnt", i), 64'({bus.cnt_a, bus.cnt_b}), 64'({tbl[i].ca, tbl[i].cb}));
    end

    // Alternating grants with both ports continuously requesting.
    do_reset();
    drive_4ph(1, 1, 6);
    chk("alt_len", 64'(grants.size()), 64'(6));
    for (int i = 0; i < grants.size(); i++)
      chk($sformatf("alt_order%0d", i), 64'(grants[i]), 64'(i % 2));
    chk("alt_cnt", 64'({bus.cnt_a, bus.cnt_b}), 64'({8'd3, 8'd3}));

    // Counter wrap on port A.
    do_reset();
    drive_4ph(1, 0, 255);
    chk("wrap_255", 64'({bus.cnt_a, bus.cnt_b}), 64'({8'd255, 8'd0}));
    drive_4ph(1, 0, 1);
    chk("wrap_0", 64'({bus.cnt_a, bus.cnt_b}), 64'({8'd0, 8'd0}));

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    bus.send_in_a = 1'b1;
    bus.send_in_b = 1'b1;
    tick();
    chk("mid_rst_pre", 64'({bus.send_out, bus.grant_b, bus.ack_out_a}), 64'(3'b101));
    #3;
    mr_n = 1'b0;
    bus.send_in_a = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({bus.send_out, bus.grant_b, bus.ack_out_a, bus.ack_out_b}), 64'(0));
    chk("mid_rst_pkt", 64'(bus.packet_out), 64'(0));
    chk("mid_rst_cnt", 64'({bus.cnt_a, bus.cnt_b}), 64'(0));
    tick();
    chk("held_rst_so", 64'(bus.send_out), 64'(0));
    mr_n = 1'b1;
    tick();
    chk("post_rst_grant", 64'({bus.send_out, bus.grant_b, bus.ack_out_b}), 64'(3'b111));
    chk("post_rst_pkt", 64'(bus.packet_out), 64'(PKT_B));

    // Stalled downstream: nothing moves for 50 cycles.
    for (int i = 0; i < 50; i++) begin
      bus.packet_in_a = PW'({$urandom(), $urandom()});
      bus.packet_in_b = PW'({$urandom(), $urandom()});
      bus.send_in_a = 1'($urandom_range(0, 1));
      tick();
      chk($sformatf("stall%0d", i), 64'({bus.send_out, bus.grant_b, bus.ack_out_b}), 64'(3'b111));
      chk($sformatf("stall%0d_pkt", i), 64'(bus.packet_out), 64'(PKT_B));
    end
    chk("stall_cnt", 64'({bus.cnt_a, bus.cnt_b}), 64'(0));

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      sa = ($urandom_range(0, 3) != 0);
      sb = ($urandom_range(0, 3) != 0);
      ai = 1'($urandom_range(0, 1));
      pa = PW'({$urandom(), $urandom()});
      pb = PW'({$urandom(), $urandom()});
      bus.send_in_a = sa;
      bus.send_in_b = sb;
      bus.ack_in = ai;
      bus.packet_in_a = pa;
      bus.packet_in_b = pb;
      m_step(sa, sb, pa, pb, ai);
      tick();
      chk("rnd_ctl",
          64'({bus.send_out, bus.grant_b, bus.ack_out_a, bus.ack_out_b, bus.cnt_a, bus.cnt_b}),
          64'({m_so, m_gb, m_ack[0], m_ack[1], CW'(m_cnt[0]), CW'(m_cnt[1])}));
      chk("rnd_pkt", 64'(bus.packet_out), 64'(m_pkt));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/b_stage_arbiter.md
B_STAGE_ARBITER -- requirements
Module: b_stage_arbiter

Interface
REQ-001 Parameter PW, default 38, packet width in bits.
REQ-002 Parameter CW, default 8, width of each per-port grant counter.
REQ-003 CP  input  1  clock; all state changes on rising edge.
REQ-004 MR_N  input  1  reset; asynchronous, active-low.
REQ-005 PACKET_IN_A  input  PW  packet from requester A.
REQ-006 Send_in_a  input  1  four-phase request from A.
REQ-007 Ack_out_a  output  1  four-phase acknowledge to A.
REQ-008 PACKET_IN_B  input  PW  packet from requester B.
REQ-009 Send_in_b  input  1  four-phase request from B.
REQ-010 Ack_out_b  output  1  four-phase acknowledge to B.
REQ-011 PACKET_OUT  output  PW  merged packet to branch stage, registered.
REQ-012 Send_out  output  1  four-phase request to branch stage.
REQ-013 Ack_in  input  1  four-phase acknowledge from branch stage.
REQ-014 GRANT_B  output  1  source of packet currently held; 0=A, 1=B.
REQ-015 CNT_A, CNT_B  output  CW each  packets forwarded per port, wrapping.

Function
REQ-016 All outputs SHALL be registered; inputs sampled on CP rising edge only.
REQ-017 FSM SHALL have states IDLE, SEND, RELEASE.
REQ-018 A port SHALL be eligible in IDLE when its Send_in is 1 and its Ack_out is 0.
REQ-019 IDLE with one eligible port: latch that port's packet into PACKET_OUT, set its Ack_out=1, set GRANT_B, Send_out=1, go SEND; all visible the cycle after sampling.
REQ-020 IDLE with both eligible: grant port selected by priority bit PRI (0=A, 1=B).
REQ-021 IDLE with none eligible: remain IDLE, outputs unchanged.
REQ-022 SEND: hold Send_out=1 and PACKET_OUT stable until Ack_in=1 sampled, then Send_out=0, go RELEASE.
REQ-023 RELEASE: wait until Ack_in=0 sampled, then go IDLE, set PRI to the port not just granted, increment that granted port's counter by 1.
REQ-024 Counters SHALL wrap from 2^CW-1 to 0 with no flag.
REQ-025 Ack_out_x SHALL clear the cycle after Send_in_x=0 is sampled, in any state, independent of downstream phase.
REQ-026 Ack_out_x SHALL never be set while Send_in_x=0 sampled or while Ack_out_x already 1.
REQ-027 Minimum turnaround: a new grant SHALL not occur before the IDLE cycle following RELEASE exit; at most one packet in flight.
REQ-028 Ack_in=1 sampled in IDLE SHALL be ignored; Ack_in=0 in SEND holds state indefinitely (no timeout).
REQ-029 Requester dropping Send_in before its Ack_out rises: no grant occurs if the drop is sampled in IDLE; a grant already registered is completed.
REQ-030 PACKET_OUT SHALL change only on a grant edge.

Reset
REQ-031 MR_N=0 SHALL immediately force IDLE, PRI=0, PACKET_OUT=0, Send_out=0, Ack_out_a=Ack_out_b=0, GRANT_B=0, CNT_A=CNT_B=0, regardless of phase.
REQ-032 Reset asserted mid-transfer SHALL abandon the packet without counter update; first grant after release follows REQ-018.
REQ-033 Release of MR_N SHALL take effect at the first CP edge with MR_N=1.

Verification
REQ-034 A only, PACKET_IN_A=38'h0012345678, Send_in_a=1, Ack_in pulsed after 2 cycles -> next cycle Ack_out_a=1, Send_out=1, PACKET_OUT=38'h0012345678, GRANT_B=0; after Ack_in falls, IDLE, CNT_A=1.
REQ-035 A and B raised same cycle from reset -> A granted first (PRI=0); after A completes and drops, B granted; CNT_A=1, CNT_B=1.
REQ-036 A and B held continuously requesting (four-phase compliant) for 6 transfers -> grant order A,B,A,B,A,B; CNT_A=CNT_B=3.
REQ-037 CW=8, 256 transfers from A -> CNT_A wraps to 0; CNT_B remains 0.
REQ-038 MR_N low while in SEND with Send_out=1 -> same edge Send_out=0, Ack_out=0, PACKET_OUT=0, CNT unchanged from 0; after release, pending B granted before A.
REQ-039 Ack_in held 0 for 50 cycles in SEND -> Send_out stays 1, PACKET_OUT stable, no further grant.
